// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Operand width, step count and the controller state encoding live here.
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_STEPS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Highest set bit index + 1, i.e. the number of steps needed when
    // trailing zero multiplier bits above the MSB are skipped.
    function automatic int active_steps(input logic [MULT_W-1:0] mplier);
        int n;
        n = 1;
        for (int i = 0; i < MULT_W; i++) begin
            if (mplier[i]) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mult_sequencer_shift_add_row.sv
// One combinational shift-add row: adds the gated multiplicand to the
// previous partial sum shifted right by one, with the row carry on top.
module shift_add_row
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic [W-1:0] mcand,
    input  logic [W-2:0] ps_hi,
    input  logic         c,
    input  logic         mbit,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         pbit
);

    logic [W:0] row;

    assign row  = {1'b0, c, ps_hi} + {1'b0, mcand & {W{mbit}}};
    assign sum  = row[W-1:0];
    assign cout = row[W];
    assign pbit = row[0];

endmodule

// File: rtl/mult_sequencer.sv
// Iterative unsigned multiplier controller: one multiplier bit per clock,
// 64-bit product delivered into hi/lo with a start/busy/done handshake.
// MULT_EARLY_TERM_EN: finish as soon as no set multiplier bits remain.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] ps;
    logic             c;
    // Bit 0 of the collected low bits would never be read, so it is not stored.
    logic [WIDTH-1:1] pbits;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             last;
    logic             no_bits_left;

    logic [WIDTH-1:0]   row_sum;
    logic               row_cout;
    logic               row_pbit;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod;

    shift_add_row #(
        .W (WIDTH)
    ) u_row (
        .mcand (mcand),
        .ps_hi (ps[WIDTH-1:1]),
        .c     (c),
        .mbit  (mplier[0]),
        .sum   (row_sum),
        .cout  (row_cout),
        .pbit  (row_pbit)
    );

    assign no_bits_left = (mplier[WIDTH-1:1] == '0);

`ifdef MULT_EARLY_TERM_EN
    assign last = step && ((cnt == CNT_W'(MULT_STEPS - 1)) || no_bits_left);
`else
    assign last = step && (cnt == CNT_W'(MULT_STEPS - 1));
`endif

    // {carry, sum, collected bits} holds the top of the product; on an early
    // finish it still has to be aligned down by the number of skipped steps.
    assign prod_raw = {row_cout, row_sum, pbits};

`ifdef MULT_EARLY_TERM_EN
    assign prod = prod_raw >> (CNT_W'(MULT_STEPS - 1) - cnt);
`else
    assign prod = prod_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        load = 1'b0;
        step = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            ps     <= '0;
            c      <= 1'b0;
            pbits  <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                mcand  <= a;
                mplier <= b;
                ps     <= '0;
                c      <= 1'b0;
                pbits  <= '0;
                cnt    <= '0;
            end else if (step) begin
                ps     <= row_sum;
                c      <= row_cout;
                pbits  <= {row_pbit, pbits[WIDTH-1:2]};
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (last) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end
        end
    end

endmodule
